// File: rtl/rom_address_sequencer_pkg.sv
// Shared definitions for the ROM address sequencer: default bus widths
// (kept in line with address_display), settle-timer width and FSM states.
package rom_address_sequencer_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 9;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned TIMER_WIDTH    = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_SAMPLE   = 3'd2,
        ST_HANDOFF  = 3'd3,
        ST_ADVANCE  = 3'd4,
        ST_DONE     = 3'd5,
        ST_REWAIT   = 3'd6,
        ST_RESAMPLE = 3'd7
    } seq_state_e;

endpackage

// File: rtl/rom_address_sequencer_if.sv
// Byte stream from the ROM sequencer to its downstream consumer.
//   data_out   : latched ROM byte (master -> slave)
//   data_valid : data_out holds a byte (master -> slave)
//   out_ready  : consumer accepts data_out this cycle (slave -> master)
interface rom_address_sequencer_if
    import rom_address_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  out_ready;

    modport master (output data_out, output data_valid, input out_ready);
    modport slave  (input data_out, input data_valid, output out_ready);

endinterface

// File: rtl/rom_address_sequencer_settle_timer.sv
// Loadable down-counter timing the ROM settle window.
//   clk, reset  : clock, asynchronous active-low reset
//   load        : load load_value (wins over dec)
//   load_value  : cycles to count
//   dec         : count down one step
//   tc_c        : high during the last counted cycle (count == 1)
module rom_address_sequencer_settle_timer
    import rom_address_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    input  logic                   dec,
    output logic                   tc_c
);

    logic [TIMER_WIDTH-1:0] count_q;

    // Counter saturates at zero so an idle timer never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - TIMER_WIDTH'(1);
        end
    end

    assign tc_c = (count_q == TIMER_WIDTH'(1));

endmodule

// File: rtl/rom_address_sequencer.sv
// Steps the ROM address bus from 0 to LAST_ADDRESS, waits SETTLE_CYCLES per
// address, latches the ROM byte and hands it downstream over out_if.
// Optional build macro ROM_DOUBLE_READ_EN: each byte is read twice, with up
// to three re-reads on mismatch before flagging read_error.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : pulse, begins a dump from address 0 (IDLE or DONE only)
//   abort        : level, returns to IDLE at the next edge
//   rom_data     : ROM data bus
//   address_line : ROM address (also feeds address_display)
//   rom_cs_n     : ROM chip select, active-low
//   rom_oe_n     : ROM output enable, active-low
//   busy, done   : dump in progress / dump finished
//   read_error   : unstable read seen (sticky until start or reset)
//   out_if       : byte stream master (data_out, data_valid, out_ready)
module rom_address_sequencer
    import rom_address_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LAST_ADDRESS  = 511
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   rom_data,
    output logic [ADDR_WIDTH-1:0]   address_line,
    output logic                    rom_cs_n,
    output logic                    rom_oe_n,
    output logic                    busy,
    output logic                    done,
    output logic                    read_error,
    rom_address_sequencer_if.master out_if
);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  en_n_q,  en_n_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic                  timer_load;
    logic                  timer_dec;
    logic                  timer_tc_c;

`ifdef ROM_DOUBLE_READ_EN
    localparam int unsigned RETRY_WIDTH   = 2;
    localparam int unsigned MAX_MISMATCH  = 3;

    logic [DATA_WIDTH-1:0]  first_q, first_d;
    logic [RETRY_WIDTH-1:0] retry_q, retry_d;
    logic                   err_q,   err_d;
`endif

    assign timer_dec = (state_q == ST_SETTLE) || (state_q == ST_REWAIT);

    rom_address_sequencer_settle_timer u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (TIMER_WIDTH'(SETTLE_CYCLES)),
        .dec        (timer_dec),
        .tc_c       (timer_tc_c)
    );

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        en_n_d     = en_n_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        timer_load = 1'b0;
`ifdef ROM_DOUBLE_READ_EN
        first_d    = first_q;
        retry_d    = retry_q;
        err_d      = err_q;
`endif

        if (abort) begin
            state_d = ST_IDLE;
            en_n_d  = 1'b1;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d    = ST_SETTLE;
                        addr_d     = '0;
                        en_n_d     = 1'b0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        timer_load = 1'b1;
`ifdef ROM_DOUBLE_READ_EN
                        err_d      = 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (timer_tc_c) begin
                        state_d = ST_SAMPLE;
                    end
                end
`ifdef ROM_DOUBLE_READ_EN
                // First sample is held for comparison after a second settle.
                ST_SAMPLE: begin
                    first_d    = rom_data;
                    retry_d    = '0;
                    timer_load = 1'b1;
                    state_d    = ST_REWAIT;
                end
                ST_REWAIT: begin
                    if (timer_tc_c) begin
                        state_d = ST_RESAMPLE;
                    end
                end
                // Last permitted mismatch delivers the newest sample anyway.
                ST_RESAMPLE: begin
                    if ((rom_data == first_q) ||
                        (retry_q == RETRY_WIDTH'(MAX_MISMATCH - 1))) begin
                        data_d  = rom_data;
                        valid_d = 1'b1;
                        state_d = ST_HANDOFF;
                        if (rom_data != first_q) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        first_d    = rom_data;
                        retry_d    = retry_q + RETRY_WIDTH'(1);
                        timer_load = 1'b1;
                        state_d    = ST_REWAIT;
                    end
                end
`else
                ST_SAMPLE: begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    state_d = ST_HANDOFF;
                end
`endif
                ST_HANDOFF: begin
                    if (out_if.out_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_ADVANCE;
                    end
                end
                // Terminate on the last address so the bus never wraps.
                ST_ADVANCE: begin
                    if (addr_q == ADDR_WIDTH'(LAST_ADDRESS)) begin
                        en_n_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d     = addr_q + ADDR_WIDTH'(1);
                        timer_load = 1'b1;
                        state_d    = ST_SETTLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            en_n_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            en_n_q  <= en_n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef ROM_DOUBLE_READ_EN
    // Double-read bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_q <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            first_q <= first_d;
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end

    assign read_error = err_q;
`else
    assign read_error = 1'b0;
`endif

    assign address_line      = addr_q;
    assign rom_cs_n          = en_n_q;
    assign rom_oe_n          = en_n_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign out_if.data_out   = data_q;
    assign out_if.data_valid = valid_q;

endmodule

// File: tb/tb_rom_address_sequencer.sv
// Directed-sequence bench with random ROM contents and random backpressure.
// Expected bytes come from a ROM image array; expected timing comes from the
// per-byte latency rule (rise-to-rise latency with ready held high).
module tb_rom_address_sequencer;

    localparam int unsigned AW   = 9;
    localparam int unsigned DW   = 8;
    localparam int          S    = 4;
    localparam int          LAST = 511;
`ifdef ROM_DOUBLE_READ_EN
    localparam int          LAT  = 2 * S + 4;
`else
    localparam int          LAT  = S + 3;
`endif
    localparam int          TOG_ADDR  = 5;
    localparam int          TOG_EXTRA = 2 * (S + 1);

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] address_line;
    logic          rom_cs_n, rom_oe_n, busy, done, read_error;

    rom_address_sequencer_if #(.DATA_WIDTH(DW)) sif ();

    rom_address_sequencer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SETTLE_CYCLES (S),
        .LAST_ADDRESS  (LAST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .rom_data     (rom_data),
        .address_line (address_line),
        .rom_cs_n     (rom_cs_n),
        .rom_oe_n     (rom_oe_n),
        .busy         (busy),
        .done         (done),
        .read_error   (read_error),
        .out_if       (sif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] rom_mem [0:(1<<AW)-1];
    bit            tog_en = 1'b0;

    // ROM model: image lookup, or an unstable bus at TOG_ADDR.
    always_comb begin
        if (tog_en && (address_line == AW'(TOG_ADDR)))
            rom_data = cyc[0] ? 8'hAA : 8'h55;
        else
            rom_data = rom_mem[address_line];
    end

    int            checks   = 0;
    int            failures = 0;
    int            exp_addr = 0;
    int            exp_rise = 0;
    int            last_xfer = 0;
    bit            prev_valid = 1'b0;
    logic [DW-1:0] held = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {address_line, rom_cs_n, rom_oe_n, sif.data_out, sif.data_valid, busy, done, read_error},
              {9'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // Pulse start and arm the scoreboard for a dump from address 0.
    task automatic begin_dump(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check(tag, {busy, done, rom_cs_n, rom_oe_n, 23'(address_line)}, {1'b1, 1'b0, 1'b0, 1'b0, 23'd0});
        exp_addr   = 0;
        prev_valid = 1'b0;
        exp_rise   = cyc + LAT - 2;
    endtask

    // Run the dump until address_line reaches stop_addr or done rises.
    task automatic run_dump(input int stop_addr, input bit rand_ready, input bit stall_at_1, input int budget);
        int stall_left = 0;
        bit stalled    = 1'b0;
        bit finished   = 1'b0;
        for (int n = 0; n < budget && !finished; n++) begin
            if (sif.data_valid && !prev_valid) begin
                if (tog_en && exp_addr == TOG_ADDR)
                    check("rise_data_tog", 32'(sif.data_out == 8'hAA || sif.data_out == 8'h55), 1);
                else
                    check("rise_data", sif.data_out, rom_mem[exp_addr]);
                check("rise_addr", address_line, exp_addr);
                check("rise_cycle", cyc, exp_rise);
                check("rise_busy", {busy, rom_cs_n, rom_oe_n}, 3'b100);
                held = sif.data_out;
            end else if (sif.data_valid) begin
                check("hold_data", sif.data_out, held);
                check("hold_addr", address_line, exp_addr);
            end
            prev_valid = sif.data_valid;
            if (done || int'(address_line) == stop_addr) begin
                finished = 1'b1;
            end else begin
                if (stall_at_1 && !stalled && sif.data_valid && exp_addr == 1) begin
                    stalled    = 1'b1;
                    stall_left = 20;
                end
                if (stall_left > 0) begin
                    sif.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    sif.out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
                end
                if (sif.data_valid && sif.out_ready) begin
                    exp_addr++;
                    last_xfer = cyc + 1;
                    exp_rise  = last_xfer + LAT - 1 + ((tog_en && exp_addr == TOG_ADDR) ? TOG_EXTRA : 0);
                end
                tick();
            end
        end
        check("dump_in_bound", 32'(finished), 1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 8'($urandom);
        sif.out_ready = 1'b0;

        // Reset held, then released with no start.
        #100;
        check_reset_vals("reset_held");
        #100;
        reset = 1'b1;
        repeat (5) tick();
        check_reset_vals("reset_idle");

        // Full dump with random backpressure and a 20-cycle stall at address 1.
        begin_dump("start_from_idle");
        run_dump(-1, 1'b1, 1'b1, 8000);
        check("done_cycle", cyc, last_xfer + 1);
        check("done_state", {done, busy, rom_cs_n, rom_oe_n, sif.data_valid}, 5'b10110);
        check("done_addr", address_line, LAST);
        check("all_bytes", exp_addr, LAST + 1);
        sif.out_ready = 1'b1;
        repeat (5) tick();
        check("done_hold", {done, 23'(address_line)}, {1'b1, 23'(LAST)});
`ifndef ROM_DOUBLE_READ_EN
        check("no_read_error", read_error, 0);
`endif

        // Restart from DONE, ignore start while busy, abort at address 124.
        begin_dump("start_from_done");
        run_dump(2, 1'b0, 1'b0, 200);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored", {busy, 23'(address_line)}, {1'b1, 23'd2});
        run_dump(124, 1'b0, 1'b0, 2000);
        abort = 1'b1;
        start = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_state", {busy, done, rom_cs_n, rom_oe_n, sif.data_valid}, 5'b00110);
        check("abort_addr", address_line, 124);
        repeat (5) tick();
        check("abort_idle", {busy, sif.data_valid, 23'(address_line)}, {1'b0, 1'b0, 23'd124});

        // Restart after abort, then reset in the middle of the dump.
        begin_dump("start_after_abort");
        run_dump(279, 1'b1, 1'b0, 4000);
        check("reach_279", address_line, 279);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("reset_async");
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b1;
        repeat (10) tick();
        check_reset_vals("post_reset_idle");

`ifdef ROM_DOUBLE_READ_EN
        // Unstable byte at TOG_ADDR: retries, flags error, still completes.
        tog_en = 1'b1;
        begin_dump("start_toggle");
        run_dump(-1, 1'b0, 1'b0, 6000);
        check("tog_error", {read_error, done}, 2'b11);
        check("tog_all_bytes", exp_addr, LAST + 1);
        tog_en = 1'b0;
        begin_dump("restart_clears");
        check("err_cleared", read_error, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_address_sequencer.md
Name: rom_address_sequencer

Overview:
- Upstream stage of address_display: steps the ROM address bus through 0..LAST_ADDRESS.
- Waits a programmable settle time per address, latches ROM data, hands each byte downstream with a valid/ready handshake.
- Its address_line output drives both the ROM chip pins and the address_display seven-segment stage.

Parameters:
- ADDR_WIDTH, 9, width of address_line (matches address_display input).
- DATA_WIDTH, 8, ROM data bus width.
- SETTLE_CYCLES, 16, clk cycles between address/OE assertion and data sampling; legal range 1..255.
- LAST_ADDRESS, 511, final address read; must be < 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle pulse; begins a dump from address 0 when IDLE or DONE.
- abort  input  1  level; forces return to IDLE at next clk edge.
- rom_data  input  DATA_WIDTH  ROM data bus.
- out_ready  input  1  downstream accepts data_out.
- address_line  output  ADDR_WIDTH  current ROM address.
- rom_cs_n  output  1  ROM chip select, active-low.
- rom_oe_n  output  1  ROM output enable, active-low.
- data_out  output  DATA_WIDTH  latched byte.
- data_valid  output  1  data_out valid.
- busy  output  1  dump in progress.
- done  output  1  dump finished.
- read_error  output  1  unstable read detected (feature-dependent).

Behaviour:
- Reset values: address_line=0, rom_cs_n=1, rom_oe_n=1, data_out=0, data_valid=0, busy=0, done=0, read_error=0, state=IDLE, settle counter=0.
- All outputs registered; reset is asynchronous and takes effect immediately, including mid-dump. On release, the block resumes from IDLE only.
- States:
  - IDLE: on start, set address_line=0, assert cs_n/oe_n=0, load counter, go to SETTLE; busy=1 from that edge.
  - SETTLE: counter decrements each cycle. After exactly SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
  - SAMPLE: latch rom_data into data_out, set data_valid=1, go to HANDOFF.
  - HANDOFF: data_valid and data_out are held stable until a cycle with out_ready=1. That edge is the transfer; data_valid drops next cycle. Go to ADVANCE.
  - ADVANCE:
    - If address_line==LAST_ADDRESS: deassert cs_n/oe_n, busy=0, done=1, go to DONE.
    - Otherwise: address_line+1, reload counter, go to SETTLE. cs_n/oe_n stay low across addresses.
  - DONE: done held until start (restart from 0, done cleared same edge) or abort (go to IDLE).
- Latency per byte, with out_ready held high: SETTLE_CYCLES + 3 cycles.
- address_line never wraps: LAST_ADDRESS terminates the dump, so there is no increment past it.
- start while busy: ignored.
- abort has priority over start and out_ready in the same cycle. It clears data_valid and busy, deasserts cs_n/oe_n, and keeps address_line at its current value.
- out_ready high while data_valid=0: no effect.

Optional Feature:
- Macro ROM_DOUBLE_READ_EN.
- Defined:
  - SAMPLE stores a first sample, waits a further SETTLE_CYCLES, and samples again.
  - Match: proceed as normal.
  - Mismatch: retry, up to 3 re-reads total. After the third mismatch, set read_error=1 (sticky until start or reset), present the last sample, and continue.
  - Per-byte latency becomes 2*SETTLE_CYCLES + 4 on a clean read.
- Undefined: single sample per address; read_error tied to 0.

Decomposition:
- Shared include rom_reader_defs.vh:
  - state encodings (IDLE, SETTLE, SAMPLE, HANDOFF, ADVANCE, DONE);
  - default ADDR_WIDTH/DATA_WIDTH, shared with address_display.
- One natural sub-module: rom_settle_timer, a loadable down-counter with a terminal-count pulse, reused for the double-read wait.

Test Plan:
- Reset: hold reset=0 for 200 ns, release, no start. All outputs stay at reset values, and address_line=0.
- Full dump: SETTLE_CYCLES=4, LAST_ADDRESS=3, out_ready=1, rom_data=address+0x10, start pulse.
  - data_out sequence: 0x10, 0x11, 0x12, 0x13.
  - Consecutive data_valid rises 7 cycles apart.
  - done=1 after address 3; address_line stays at 3.
- Backpressure: out_ready=0 for 20 cycles at address 1. data_valid and data_out=0x11 are held stable, address_line stays at 1, and the sequence resumes when out_ready=1.
- Abort: abort at address 124 during SETTLE. Next edge: busy=0, rom_cs_n=1, data_valid=0, address_line=124. A subsequent start restarts at 0.
- Reset mid-dump: reset=0 at address 279. Outputs go to reset values asynchronously (before next clk edge), and the block stays IDLE after release.
- With ROM_DOUBLE_READ_EN: rom_data toggles 0xAA/0x55 every cycle at address 5. After 3 re-reads, read_error=1, a byte is still delivered, and the dump completes.
